// File: rtl/nzcv_flag_ctrl.sv
// nzcv_flag_ctrl: architectural NZCV register, pending flag-producer tracking
// and a valid/ready condition-code evaluator for the issue stage.
// Optional build macro: NZCV_FLAG_FWD_EN forwards alu_nzcv into a waiting
// evaluation when the last outstanding flag producer commits.
module nzcv_flag_ctrl #(
  parameter int PEND_MAX = 3  // legal range 1..7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alu_nzcv,
  input  logic       flag_we,
  input  logic       set_pend,
  input  logic       msr_we,
  input  logic [3:0] msr_data,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_ready,
  output logic       pass_valid,
  output logic       pass,
  input  logic       pass_ready,
  output logic [3:0] flags_q,
  output logic       c_out,
  output logic       v_out,
  output logic       pend_err
);

  localparam logic [2:0] PEND_MAX_C = 3'(PEND_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_d;
  logic [2:0] pend_cnt_q, pend_cnt_d;
  logic       pend_err_q, pend_err_d;
  logic       pass_q, pass_d;
  logic [3:0] cond_q, cond_d;
  logic       fwd_hit;

  // ARM condition-code decode; f is {N, Z, C, V}
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = cy;
      4'h3:    eval_cond = !cy;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = cy & !z;
      4'h9:    eval_cond = !cy | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // The last outstanding producer is committing this cycle with no new one
  // arriving, so its result can be used directly instead of waiting a cycle.
`ifdef NZCV_FLAG_FWD_EN
  assign fwd_hit = (pend_cnt_q == 3'd1) && flag_we && !set_pend;
`else
  assign fwd_hit = 1'b0;
`endif

  // Flag register write priority, pending counter and sticky protocol error
  always_comb begin
    flags_d    = flags_q;
    pend_cnt_d = pend_cnt_q;
    pend_err_d = pend_err_q;
    if (flag_we) begin
      flags_d = alu_nzcv;
    end else if (msr_we) begin
      if (pend_cnt_q == 3'd0) flags_d = msr_data;
      else                    pend_err_d = 1'b1;
    end
    if (set_pend && !flag_we) begin
      if (pend_cnt_q == PEND_MAX_C) pend_err_d = 1'b1;
      else                          pend_cnt_d = pend_cnt_q + 3'd1;
    end else if (flag_we && !set_pend) begin
      if (pend_cnt_q == 3'd0) pend_err_d = 1'b1;
      else                    pend_cnt_d = pend_cnt_q - 3'd1;
    end
  end

  // Evaluation FSM: accept request, wait out pending producers, hold response
  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    pass_d     = pass_q;
    cond_ready = 1'b0;
    pass_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cond_ready = 1'b1;
        if (cond_valid) begin
          cond_d = cond;
          if (pend_cnt_q == 3'd0) begin
            pass_d  = eval_cond(cond, flags_q);
            state_d = RESP;
          end else if (fwd_hit) begin
            pass_d  = eval_cond(cond, alu_nzcv);
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (pend_cnt_q == 3'd0) begin
          pass_d  = eval_cond(cond_q, flags_q);
          state_d = RESP;
        end else if (fwd_hit) begin
          pass_d  = eval_cond(cond_q, alu_nzcv);
          state_d = RESP;
        end
      end
      RESP: begin
        pass_valid = 1'b1;
        if (pass_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flags_q    <= 4'b0000;
      pend_cnt_q <= 3'd0;
      pend_err_q <= 1'b0;
      pass_q     <= 1'b0;
      cond_q     <= 4'h0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      pend_cnt_q <= pend_cnt_d;
      pend_err_q <= pend_err_d;
      pass_q     <= pass_d;
      cond_q     <= cond_d;
    end
  end

  assign pass     = pass_q;
  assign pend_err = pend_err_q;
  assign c_out    = flags_q[1];
  assign v_out    = flags_q[0];

endmodule

// File: tb/tb_nzcv_flag_ctrl.sv
// Testbench for nzcv_flag_ctrl: condition table, hand-written multi-cycle
// sequences and a randomized run checked against a request-level model.
module tb_nzcv_flag_ctrl;

`ifdef NZCV_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_nzcv = '0;
  logic       flag_we = 1'b0;
  logic       set_pend = 1'b0;
  logic       msr_we = 1'b0;
  logic [3:0] msr_data = '0;
  logic       cond_valid = 1'b0;
  logic [3:0] cond = '0;
  logic       cond_ready;
  logic       pass_valid;
  logic       pass;
  logic       pass_ready = 1'b0;
  logic [3:0] flags_q;
  logic       c_out;
  logic       v_out;
  logic       pend_err;

  nzcv_flag_ctrl #(.PEND_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .alu_nzcv(alu_nzcv), .flag_we(flag_we),
    .set_pend(set_pend), .msr_we(msr_we), .msr_data(msr_data),
    .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
    .pass_valid(pass_valid), .pass(pass), .pass_ready(pass_ready),
    .flags_q(flags_q), .c_out(c_out), .v_out(v_out), .pend_err(pend_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: architectural flags, outstanding producer count,
  // one outstanding request and one presented response.
  int         m_cnt;
  logic [3:0] m_flags;
  bit         m_err;
  bit         m_have_req;
  int         m_cond;
  bit         m_resp_out;
  bit         m_pass;

  function automatic bit ref_eval(input int c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ (c % 2 == 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_flags = 4'b0000; m_err = 0;
    m_have_req = 0; m_cond = 0; m_resp_out = 0; m_pass = 0;
  endtask

  // One rising edge of the model, using the inputs currently driven
  task automatic model_clock();
    bit ready_now;
    int cnt_now;
    ready_now = !m_have_req && !m_resp_out;
    cnt_now   = m_cnt;
    if (m_resp_out && pass_ready) m_resp_out = 0;
    if (ready_now && cond_valid) begin
      m_have_req = 1;
      m_cond     = int'(cond);
    end
    if (m_have_req) begin
      if (cnt_now == 0) begin
        m_pass = ref_eval(m_cond, m_flags);
        m_have_req = 0; m_resp_out = 1;
      end else if (FWD && cnt_now == 1 && flag_we && !set_pend) begin
        m_pass = ref_eval(m_cond, alu_nzcv);
        m_have_req = 0; m_resp_out = 1;
      end
    end
    if (flag_we) m_flags = alu_nzcv;
    else if (msr_we) begin
      if (cnt_now == 0) m_flags = msr_data;
      else m_err = 1;
    end
    if (set_pend && !flag_we) begin
      if (cnt_now == 3) m_err = 1; else m_cnt = cnt_now + 1;
    end else if (flag_we && !set_pend) begin
      if (cnt_now == 0) m_err = 1; else m_cnt = cnt_now - 1;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".cond_ready"}, 4'(cond_ready), 4'(!m_have_req && !m_resp_out));
    chk({tag, ".pass_valid"}, 4'(pass_valid), 4'(m_resp_out));
    if (m_resp_out) chk({tag, ".pass"}, 4'(pass), 4'(m_pass));
    chk({tag, ".flags_q"}, flags_q, m_flags);
    chk({tag, ".c_out"}, 4'(c_out), 4'(m_flags[1]));
    chk({tag, ".v_out"}, 4'(v_out), 4'(m_flags[0]));
    chk({tag, ".pend_err"}, 4'(pend_err), 4'(m_err));
  endtask

  // Drive one cycle of inputs (from a negedge), clock, and check at negedge
  task automatic step(input string tag, input logic fw, input logic [3:0] alu,
                      input logic sp, input logic mw, input logic [3:0] md,
                      input logic cv, input logic [3:0] cc, input logic pr);
    flag_we = fw; alu_nzcv = alu; set_pend = sp; msr_we = mw; msr_data = md;
    cond_valid = cv; cond = cc; pass_ready = pr;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    $display("cyc %s fw=%b alu=%h sp=%b msr=%b/%h cv=%b cond=%h pr=%b -> flags=%h pv=%b pass=%b cr=%b err=%b",
             tag, fw, alu, sp, mw, md, cv, cc, pr, flags_q, pass_valid, pass, cond_ready, pend_err);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic pr);
    step(tag, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, pr);
  endtask

  task automatic do_reset();
    flag_we = 0; set_pend = 0; msr_we = 0; cond_valid = 0; pass_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs("release");
  endtask

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cc;
    logic       exp_pass;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'b0100, 4'h0, 1'b1};  // EQ, Z=1
    vecs[1]  = '{4'b0100, 4'h1, 1'b0};  // NE
    vecs[2]  = '{4'b1001, 4'hA, 1'b1};  // GE
    vecs[3]  = '{4'b1001, 4'hB, 1'b0};  // LT
    vecs[4]  = '{4'b1001, 4'hC, 1'b1};  // GT
    vecs[5]  = '{4'b1001, 4'hD, 1'b0};  // LE
    vecs[6]  = '{4'b1001, 4'hE, 1'b1};  // AL
    vecs[7]  = '{4'b1001, 4'hF, 1'b0};  // NV
    vecs[8]  = '{4'b0010, 4'h8, 1'b1};  // HI
    vecs[9]  = '{4'b0110, 4'h9, 1'b1};  // LS via Z
    vecs[10] = '{4'b0010, 4'h3, 1'b0};  // CC
    vecs[11] = '{4'b1000, 4'h5, 1'b0};  // PL

    @(negedge clk);
    do_reset();

    // Condition table: set flags by msr, request, check one-cycle latency
    foreach (vecs[i]) begin
      step("tbl_msr", 0, 0, 0, 1, vecs[i].flags, 0, 0, 0);
      step("tbl_req", 0, 0, 0, 0, 0, 1, vecs[i].cc, 0);
      chk($sformatf("tbl%0d.pv", i), 4'(pass_valid), 4'd1);
      chk($sformatf("tbl%0d.pass", i), 4'(pass), 4'(vecs[i].exp_pass));
      idle("tbl_ack", 1);
    end

    // Dependency stall: two producers, accept at T, commits at T+2 and T+4
    step("dep_sp", 0, 0, 1, 0, 0, 0, 0, 0);
    step("dep_sp", 0, 0, 1, 0, 0, 0, 0, 0);
    step("dep_T", 0, 0, 0, 0, 0, 1, 4'h2, 0);
    idle("dep_T1", 0);
    step("dep_T2", 1, 4'b0010, 0, 0, 0, 0, 0, 0);
    idle("dep_T3", 0);
    step("dep_T4", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("dep_valid_at_T5", 4'(pass_valid), 4'(FWD));
    if (!FWD) idle("dep_T5", 0);
    chk("dep_pv", 4'(pass_valid), 4'd1);
    chk("dep_pass", 4'(pass), 4'd0);
    chk("dep_flags", flags_q, 4'b0000);
    idle("dep_ack", 1);

    // Backpressure while flags keep changing (flag_we with nothing pending)
    step("bp_msr", 0, 0, 0, 1, 4'b1001, 0, 0, 0);
    step("bp_req", 0, 0, 0, 0, 0, 1, 4'hA, 0);
    for (int k = 0; k < 5; k++) begin
      step("bp_hold", 1, 4'($urandom_range(0, 15)), 0, 0, 0, 1, 4'hF, 0);
      chk("bp_pv", 4'(pass_valid), 4'd1);
      chk("bp_pass", 4'(pass), 4'd1);
      chk("bp_cr", 4'(cond_ready), 4'd0);
    end
    chk("bp_err_flagwe_at_0", 4'(pend_err), 4'd1);
    idle("bp_ack", 1);
    idle("bp_after", 0);

    // Overflow: PEND_MAX+1 set_pend pulses, count saturates at 3
    do_reset();
    for (int k = 0; k < 4; k++) step("ovf_sp", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("ovf_err", 4'(pend_err), 4'd1);
    step("ovf_req", 0, 0, 0, 0, 0, 1, 4'hE, 1);
    step("ovf_fw", 1, 4'h1, 0, 0, 0, 0, 0, 1);
    step("ovf_fw", 1, 4'h2, 0, 0, 0, 0, 0, 1);
    chk("ovf_still_waiting", 4'(pass_valid), 4'd0);
    step("ovf_fw", 1, 4'h3, 0, 0, 0, 0, 0, 1);
    repeat (3) idle("ovf_drain", 1);

    // msr blocked while a producer is outstanding
    do_reset();
    step("msr_ok", 0, 0, 0, 1, 4'b0101, 0, 0, 0);
    step("msr_sp", 0, 0, 1, 0, 0, 0, 0, 0);
    step("msr_blk", 0, 0, 0, 1, 4'b1111, 0, 0, 0);
    chk("msr_blk_flags", flags_q, 4'b0101);
    chk("msr_blk_err", 4'(pend_err), 4'd1);
    step("msr_fw", 1, 4'b0011, 0, 1, 4'b1100, 0, 0, 0);
    chk("fw_beats_msr", flags_q, 4'b0011);

    // Reset while in WAIT
    do_reset();
    step("rw_msr", 0, 0, 0, 1, 4'b1111, 0, 0, 0);
    step("rw_sp", 0, 0, 1, 0, 0, 0, 0, 0);
    step("rw_req", 0, 0, 0, 0, 0, 1, 4'h0, 0);
    idle("rw_wait", 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rw_flags", flags_q, 4'b0000);
    chk("rw_pv", 4'(pass_valid), 4'd0);
    chk("rw_err", 4'(pend_err), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_cr", 4'(cond_ready), 4'd1);
    step("rw_req2", 0, 0, 0, 0, 0, 1, 4'h1, 1);
    chk("rw_cnt_cleared", 4'(pass_valid), 4'd1);
    idle("rw_done", 1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      step("rnd",
           logic'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)), logic'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), logic'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
